// File: rtl/bdi_firstbase_compressor_if.sv
// Valid/ready bundle for the BDI first-base compressor: raw line in, encoded line out.
interface bdi_firstbase_compressor_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_line;
  logic         out_valid;
  logic         out_ready;
  logic [259:0] out_data;
  logic [8:0]   out_size;

  // Compressor view
  modport slave (
    input  in_valid, in_line, out_ready,
    output in_ready, out_valid, out_data, out_size
  );

  // Line source / encoded-line consumer view
  modport master (
    output in_valid, in_line, out_ready,
    input  in_ready, out_valid, out_data, out_size
  );
endinterface

// File: rtl/bdi_firstbase_compressor.sv
// BDI compressor with element 0 as the fixed base. One line in flight; the
// candidate encodings are tried one per cycle, smallest encoding first, and the
// first one that fits is packed into the 260-bit format the decompressor reads.
module bdi_firstbase_compressor #(
  parameter int CNT_W   = 16,
  parameter bit EN_B2D1 = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bdi_firstbase_compressor_if.slave  bus,
  output logic                       busy,
  output logic [CNT_W-1:0]           lines_done
);

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  state_t       state;
  state_t       state_next;
  logic [255:0] line;
  logic [2:0]   cand;
  logic [7:0]   fit;
  logic [259:0] cand_data;
  logic [8:0]   cand_size;
  logic [259:0] data_q;
  logic [8:0]   size_q;
  logic         done_eval;

  // 64-bit elements: every |v - base| must fit in d bytes
  function automatic logic fit_b8(input logic [255:0] l, input int d);
    logic [63:0] b, v, m;
    logic        ok;
    b  = l[63:0];
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = l[64*i +: 64];
      m = (v >= b) ? v - b : b - v;
      if ((m >> (8*d)) != 64'd0) ok = 1'b0;
    end
    return ok;
  endfunction

  // 32-bit elements: every |v - base| must fit in d bytes
  function automatic logic fit_b4(input logic [255:0] l, input int d);
    logic [31:0] b, v, m;
    logic        ok;
    b  = l[31:0];
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = l[32*i +: 32];
      m = (v >= b) ? v - b : b - v;
      if ((m >> (8*d)) != 32'd0) ok = 1'b0;
    end
    return ok;
  endfunction

  // 16-bit elements: every |v - base| must fit in one byte
  function automatic logic fit_b2(input logic [255:0] l);
    logic [15:0] b, v, m;
    logic        ok;
    b  = l[15:0];
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = l[16*i +: 16];
      m = (v >= b) ? v - b : b - v;
      if (m[15:8] != 8'd0) ok = 1'b0;
    end
    return ok;
  endfunction

  // 64-bit base: flags [7:4], base [71:8], d-byte magnitudes from bit 72
  function automatic logic [259:0] pack_b8(input logic [255:0] l, input int d, input logic [3:0] con);
    logic [259:0] r;
    logic [63:0]  b, v, m;
    r        = '0;
    r[3:0]   = con;
    b        = l[63:0];
    r[71:8]  = b;
    for (int i = 0; i < 4; i++) begin
      v        = l[64*i +: 64];
      r[4+i]   = (v >= b);
      m        = (v >= b) ? v - b : b - v;
      for (int j = 0; j < 32; j++)
        if (j < 8*d) r[72 + 8*d*i + j] = m[j];
    end
    return r;
  endfunction

  // 32-bit base: flags [11:4], base [43:12], d-byte magnitudes from bit 44
  function automatic logic [259:0] pack_b4(input logic [255:0] l, input int d, input logic [3:0] con);
    logic [259:0] r;
    logic [31:0]  b, v, m;
    r        = '0;
    r[3:0]   = con;
    b        = l[31:0];
    r[43:12] = b;
    for (int i = 0; i < 8; i++) begin
      v        = l[32*i +: 32];
      r[4+i]   = (v >= b);
      m        = (v >= b) ? v - b : b - v;
      for (int j = 0; j < 16; j++)
        if (j < 8*d) r[44 + 8*d*i + j] = m[j];
    end
    return r;
  endfunction

  // 16-bit base: element 0 flag sits at bit 19, the other flags at 3+i
  function automatic logic [259:0] pack_b2(input logic [255:0] l);
    logic [259:0] r;
    logic [15:0]  b, v, m;
    r        = '0;
    r[3:0]   = 4'd7;
    b        = l[15:0];
    r[35:20] = b;
    for (int i = 0; i < 16; i++) begin
      v = l[16*i +: 16];
      m = (v >= b) ? v - b : b - v;
      if (i == 0) r[19]    = (v >= b);
      else        r[3 + i] = (v >= b);
      r[36 + 8*i +: 8] = m[7:0];
    end
    return r;
  endfunction

  // Fit test for every candidate on the captured line
  always_comb begin
    fit    = '0;
    fit[0] = (line == '0);
    fit[1] = (line[63:0] == line[127:64]) && (line[63:0] == line[191:128]) &&
             (line[63:0] == line[255:192]);
    fit[2] = fit_b8(line, 1);
    fit[3] = fit_b4(line, 1);
    fit[4] = fit_b8(line, 2);
    fit[5] = (EN_B2D1 != 1'b0) && fit_b2(line);
    fit[6] = fit_b4(line, 2);
    fit[7] = fit_b8(line, 4);
  end

  // Packed encoding of the current candidate; raw fallback when it does not fit
  always_comb begin
    cand_data = '0;
    cand_size = '0;
    case (cand)
      3'd0: begin cand_data = '0;                      cand_size = 9'd4;   end
      3'd1: begin cand_data[3:0]  = 4'd1;
                  cand_data[67:4] = line[63:0];        cand_size = 9'd68;  end
      3'd2: begin cand_data = pack_b8(line, 1, 4'd2);  cand_size = 9'd104; end
      3'd3: begin cand_data = pack_b4(line, 1, 4'd5);  cand_size = 9'd108; end
      3'd4: begin cand_data = pack_b8(line, 2, 4'd3);  cand_size = 9'd136; end
      3'd5: begin cand_data = pack_b2(line);           cand_size = 9'd164; end
      3'd6: begin cand_data = pack_b4(line, 2, 4'd6);  cand_size = 9'd172; end
      default: begin cand_data = pack_b8(line, 4, 4'd4); cand_size = 9'd200; end
    endcase
    if (!fit[cand]) begin
      cand_data = {line, 4'hF};
      cand_size = 9'd260;
    end
  end

  assign done_eval = fit[cand] || (cand == 3'd7);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = EVAL;
      EVAL:    if (done_eval)     state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line capture, candidate stepping, result register and handoff counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line       <= '0;
      cand       <= '0;
      data_q     <= '0;
      size_q     <= '0;
      lines_done <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          line <= bus.in_line;
          cand <= 3'd0;
        end
        EVAL: if (done_eval) begin
          data_q <= cand_data;
          size_q <= cand_size;
        end else begin
          cand <= cand + 3'd1;
        end
        OUT: if (bus.out_ready) lines_done <= lines_done + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = data_q;
  assign bus.out_size  = size_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_bdi_firstbase_compressor.sv
// Self-checking bench for bdi_firstbase_compressor: directed lines plus random
// lines aimed at each encoding, checked against a table-driven reference
// encoder and a reference decompressor (round trip back to the raw line).
module tb_bdi_firstbase_compressor;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] lines_done;
  int               vectors     = 0;
  int               miscompares = 0;
  int               exp_done    = 0;

  // Candidate k: element width, delta bytes, CoN code, total bits
  int w_tab    [8] = '{0, 0, 64, 32, 64, 16, 32, 64};
  int d_tab    [8] = '{0, 0, 1, 1, 2, 1, 2, 4};
  int con_tab  [8] = '{0, 1, 2, 5, 3, 7, 6, 4};
  int size_tab [8] = '{4, 68, 104, 108, 136, 164, 172, 200};

  bdi_firstbase_compressor_if bus();

  bdi_firstbase_compressor #(.CNT_W(CNT_W), .EN_B2D1(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .busy       (busy),
    .lines_done (lines_done)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned elem(input logic [255:0] l, input int w, input int i);
    longint unsigned r;
    r = 0;
    for (int j = 0; j < w; j++) r[j] = l[w*i + j];
    return r;
  endfunction

  function automatic bit model_fits(input logic [255:0] l, input int k);
    longint unsigned b, v, m, lim;
    int w;
    if (k == 0) return (l == 256'd0);
    if (k == 1) return (elem(l, 64, 0) == elem(l, 64, 1)) && (elem(l, 64, 0) == elem(l, 64, 2)) &&
                       (elem(l, 64, 0) == elem(l, 64, 3));
    w   = w_tab[k];
    lim = 64'd1 << (8 * d_tab[k]);
    b   = elem(l, w, 0);
    for (int i = 0; i < 256 / w; i++) begin
      v = elem(l, w, i);
      m = (v >= b) ? v - b : b - v;
      if (m >= lim) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference encoder; k = chosen candidate, 8 = uncompressed
  task automatic model_encode(input logic [255:0] l, output logic [259:0] d, output int size, output int k);
    longint unsigned b, v, m;
    int w, dd, n, bp, fp;
    k = 8;
    for (int c = 7; c >= 0; c--) if (model_fits(l, c)) k = c;
    d = '0;
    if (k == 8) begin
      d    = {l, 4'hF};
      size = 260;
      return;
    end
    size   = size_tab[k];
    d[3:0] = con_tab[k][3:0];
    if (k == 1) begin
      for (int j = 0; j < 64; j++) d[4 + j] = l[j];
    end else if (k >= 2) begin
      w  = w_tab[k];
      dd = d_tab[k];
      n  = 256 / w;
      bp = 4 + n;
      b  = elem(l, w, 0);
      for (int j = 0; j < w; j++) d[bp + j] = b[j];
      for (int i = 0; i < n; i++) begin
        v  = elem(l, w, i);
        m  = (v >= b) ? v - b : b - v;
        fp = (w == 16) ? ((i == 0) ? 19 : 3 + i) : 4 + i;
        d[fp] = (v >= b);
        for (int j = 0; j < 8*dd; j++) d[bp + w + 8*dd*i + j] = m[j];
      end
    end
  endtask

  // Reference decompressor
  function automatic logic [255:0] model_decode(input logic [259:0] d);
    logic [255:0] r;
    longint unsigned b, m, v;
    int k, w, dd, n, bp, fp;
    r = '0;
    k = -1;
    if (d[3:0] == 4'd0)  return '0;
    if (d[3:0] == 4'hF)  return d[259:4];
    if (d[3:0] == 4'd1) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 64; j++) r[64*i + j] = d[4 + j];
      return r;
    end
    for (int c = 2; c < 8; c++) if (con_tab[c] == int'(d[3:0])) k = c;
    if (k < 0) return 'x;
    w  = w_tab[k];
    dd = d_tab[k];
    n  = 256 / w;
    bp = 4 + n;
    b  = 0;
    for (int j = 0; j < w; j++) b[j] = d[bp + j];
    for (int i = 0; i < n; i++) begin
      m = 0;
      for (int j = 0; j < 8*dd; j++) m[j] = d[bp + w + 8*dd*i + j];
      fp = (w == 16) ? ((i == 0) ? 19 : 3 + i) : 4 + i;
      v  = d[fp] ? b + m : b - m;
      for (int j = 0; j < w; j++) r[w*i + j] = v[j];
    end
    return r;
  endfunction

  // Random line shaped around candidate 'kind'; kind >= 8 gives a fully random line
  function automatic logic [255:0] gen_line(input int kind);
    logic [255:0] l;
    longint unsigned b, m, v, lim;
    int w;
    l = '0;
    if (kind == 0) return l;
    if (kind == 1) begin
      b = {$urandom, $urandom};
      return {4{b}};
    end
    if (kind >= 8) begin
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
    end
    w   = w_tab[kind];
    lim = 64'd1 << (8 * d_tab[kind]);
    b   = {$urandom, $urandom};
    for (int i = 0; i < 256 / w; i++) begin
      if (i == 0) v = b;
      else begin
        m = longint'($urandom) & (lim - 1);
        if ($urandom_range(0, 3) == 0) m = lim - 1;
        v = ($urandom_range(0, 1) == 1) ? b + m : b - m;
      end
      for (int j = 0; j < w; j++) l[w*i + j] = v[j];
    end
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Send one line, wait for the encoding, check it, optionally stall, then hand off
  task automatic applyStimulus(input logic [255:0] l, input int hold);
    logic [259:0] ed;
    int es, ek, edges, exp_lat;
    model_encode(l, ed, es, ek);
    exp_lat = (ek == 8) ? 9 : ek + 2;
    bus.out_ready = 1'b0;
    bus.in_line   = l;
    bus.in_valid  = 1'b1;
    edges = 0;
    while (!bus.in_ready && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("in_ready_idle", 260'(bus.in_ready), 260'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_line  = gen_line(8);
    // The handshake cycle is cycle 0, so the cycle after the n-th edge is cycle n+1
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency", 260'(edges + 1), 260'(exp_lat));
    checkOutput("out_data", bus.out_data, ed);
    checkOutput("out_size", 260'(bus.out_size), 260'(es));
    checkOutput("roundtrip", 260'(model_decode(bus.out_data)), 260'(l));
    checkOutput("busy_out", 260'(busy), 260'(1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 260'(bus.out_valid), 260'(1));
      checkOutput("hold_data", bus.out_data, ed);
      checkOutput("hold_size", 260'(bus.out_size), 260'(es));
      checkOutput("hold_in_ready", 260'(bus.in_ready), 260'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_done++;
    checkOutput("lines_done", 260'(lines_done), 260'(exp_done % (1 << CNT_W)));
    checkOutput("valid_dropped", 260'(bus.out_valid), 260'(0));
    checkOutput("busy_idle", 260'(busy), 260'(0));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"}, 260'(bus.in_ready), 260'(1));
    checkOutput({tag, "_out_valid"}, 260'(bus.out_valid), 260'(0));
    checkOutput({tag, "_out_data"}, bus.out_data, 260'(0));
    checkOutput({tag, "_out_size"}, 260'(bus.out_size), 260'(0));
    checkOutput({tag, "_busy"}, 260'(busy), 260'(0));
    checkOutput({tag, "_lines_done"}, 260'(lines_done), 260'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_line   = '0;
    bus.out_ready = 1'b0;
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] T1 zero line");
    applyStimulus(256'd0, 0);
    $display("[TB] T2 repeated 64-bit element");
    applyStimulus({4{64'h1234_5678_9ABC_DEF0}}, 0);
    $display("[TB] T3 B8D1 with a 0xFF boundary magnitude");
    applyStimulus({64'h10FF, 64'h0FFB, 64'h1005, 64'h1000}, 0);
    $display("[TB] T4 32-bit magnitude of 256");
    applyStimulus({32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h100}, 0);
    $display("[TB] T4b 64-bit magnitude of 256");
    applyStimulus({64'h1100, 64'h0F00, 64'h1100, 64'h1000}, 0);
    $display("[TB] T5 random line with output stall");
    applyStimulus(gen_line(8), 5);

    $display("[TB] random lines");
    for (int n = 0; n < 24; n++) applyStimulus(gen_line(n % 9), 0);

    $display("[TB] T6 reset during evaluation");
    bus.in_line  = gen_line(8);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    exp_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(gen_line(3), 0);
    applyStimulus(gen_line(5), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
